pwm_softstart_seq: RTL and testbench

Soft-start / soft-stop sequencer that sits between the switch bank and the open-loop PWM stage on the 200 MHz clock. It takes a raw enable, a duty target and two deadtime requests. It drives the PWM stage with a slew-limited duty, clamped deadtimes and a gated enable. It also latches an external fault and forces the bridge off until the fault is cleared and the operator releases enable.

---
 rtl/pwm_softstart_seq.sv | 106 ++++++++++
 tb/tb_pwm_softstart_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_softstart_seq.sv
// pwm_softstart_seq: slew-limited soft-start/soft-stop sequencer with latched fault for the PWM stage
module pwm_softstart_seq #(
  parameter int          STEP_DIV   = 2000,
  parameter logic [7:0]  DUTY_MAX   = 8'd230,
  parameter logic [3:0]  DT_MIN     = 4'd2,
  parameter logic [19:0] FAULT_HOLD = 20'd200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       i_fault,
  input  logic [7:0] i_sw_duty,
  input  logic [3:0] i_sw_dt1,
  input  logic [3:0] i_sw_dt2,
  output logic [7:0] o_duty,
  output logic [3:0] o_dt1,
  output logic [3:0] o_dt2,
  output logic       o_pwm_en,
  output logic [2:0] o_state,
  output logic       o_fault
);
  typedef enum logic [2:0] {IDLE = 3'd0, RAMP_UP = 3'd1, RUN = 3'd2, RAMP_DOWN = 3'd3, FAULT = 3'd4} state_t;
  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [19:0] hold;
  logic en_q, en_s, flt_q, flt_s, tick, load_dt;
  logic [7:0] tgt, slew, duty_n;
  assign tgt = (i_sw_duty > DUTY_MAX) ? DUTY_MAX : i_sw_duty;
  assign tick = cnt == CW'(STEP_DIV - 1);
  assign slew = !tick ? o_duty : (o_duty < tgt) ? o_duty + 8'd1 : (o_duty > tgt) ? o_duty - 8'd1 : o_duty;
  assign o_state = state;
  // Next state and next duty; fault beats enable-drop, and any transition other than
  // reaching the target suppresses the step on that edge.
  always_comb begin
    state_n = state;
    duty_n  = o_duty;
    load_dt = 1'b0;
    if (flt_s) begin
      state_n = FAULT;
      duty_n  = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          duty_n = 8'd0;
          if (en_s) begin
            state_n = RAMP_UP;
            load_dt = 1'b1;
          end
        end
        RAMP_UP, RUN: begin
          if (!en_s) state_n = RAMP_DOWN;
          else begin
            duty_n = slew;
            if (state == RAMP_UP && slew == tgt) state_n = RUN;
          end
        end
        RAMP_DOWN: begin
          if (en_s) state_n = RAMP_UP;
          else if (o_duty == 8'd0) state_n = IDLE;
          else if (tick) duty_n = o_duty - 8'd1;
        end
        FAULT: begin
          duty_n = 8'd0;
          if (hold == FAULT_HOLD - 20'd1 && !en_s) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          duty_n  = 8'd0;
        end
      endcase
    end
  end
  // Synchronizers, state, step/hold counters and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q     <= 1'b0;
      en_s     <= 1'b0;
      flt_q    <= 1'b0;
      flt_s    <= 1'b0;
      state    <= IDLE;
      o_duty   <= 8'd0;
      cnt      <= '0;
      hold     <= 20'd0;
      o_pwm_en <= 1'b0;
      o_fault  <= 1'b0;
      o_dt1    <= DT_MIN;
      o_dt2    <= DT_MIN;
    end else begin
      en_q     <= enable;
      en_s     <= en_q;
      flt_q    <= i_fault;
      flt_s    <= flt_q;
      state    <= state_n;
      o_duty   <= duty_n;
      cnt      <= (state_n != state || tick) ? '0 : cnt + 1'b1;
      hold     <= (state != FAULT) ? 20'd0 : (hold == FAULT_HOLD - 20'd1) ? hold : hold + 20'd1;
      o_pwm_en <= state_n inside {RAMP_UP, RUN, RAMP_DOWN};
      o_fault  <= state_n == FAULT;
      if (load_dt) begin
        o_dt1 <= (i_sw_dt1 < DT_MIN) ? DT_MIN : i_sw_dt1;
        o_dt2 <= (i_sw_dt2 < DT_MIN) ? DT_MIN : i_sw_dt2;
      end
    end
  end
endmodule

// File: tb/tb_pwm_softstart_seq.sv
// tb_pwm_softstart_seq: directed scenarios plus random stimulus checked every cycle against a behavioural model
module tb_pwm_softstart_seq;
  localparam int SD = 4, DMAX = 200, DTMIN = 2, HOLD = 8;
  logic clk, rst, enable, i_fault;
  logic [7:0] i_sw_duty, o_duty;
  logic [3:0] i_sw_dt1, i_sw_dt2, o_dt1, o_dt2;
  logic o_pwm_en, o_fault;
  logic [2:0] o_state;
  int checks = 0, errors = 0;

  pwm_softstart_seq #(.STEP_DIV(SD), .DUTY_MAX(8'd200), .DT_MIN(4'd2), .FAULT_HOLD(20'd8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .i_fault(i_fault), .i_sw_duty(i_sw_duty),
    .i_sw_dt1(i_sw_dt1), .i_sw_dt2(i_sw_dt2), .o_duty(o_duty), .o_dt1(o_dt1), .o_dt2(o_dt2),
    .o_pwm_en(o_pwm_en), .o_state(o_state), .o_fault(o_fault));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: st = state code, age = cycles spent in the current state, e/f = sync pipeline stages.
  typedef struct packed { int st; int duty; int dt1; int dt2; int age; int e1; int e2; int f1; int f2; } mdl_t;
  mdl_t m;

  function automatic mdl_t rst_m();
    mdl_t r;
    r = '0;
    r.dt1 = DTMIN;
    r.dt2 = DTMIN;
    return r;
  endfunction

  function automatic mdl_t nxt(mdl_t c, int en_in, int f_in, int sd, int d1, int d2);
    mdl_t r;
    int t, toward;
    bit tick;
    r = c;
    t = (sd > DMAX) ? DMAX : sd;
    tick = (c.age % SD) == SD - 1;
    toward = !tick ? c.duty : c.duty + int'(c.duty < t) - int'(c.duty > t);
    r.e1 = en_in; r.e2 = c.e1; r.f1 = f_in; r.f2 = c.f1;
    if (c.f2 != 0) begin
      r.st = 4; r.duty = 0;
    end else if (c.st == 0) begin
      r.duty = 0;
      if (c.e2 != 0) begin
        r.st = 1; r.dt1 = (d1 < DTMIN) ? DTMIN : d1; r.dt2 = (d2 < DTMIN) ? DTMIN : d2;
      end
    end else if (c.st == 1 || c.st == 2) begin
      if (c.e2 == 0) r.st = 3;
      else begin
        r.duty = toward;
        if (c.st == 1 && toward == t) r.st = 2;
      end
    end else if (c.st == 3) begin
      if (c.e2 != 0) r.st = 1;
      else if (c.duty == 0) r.st = 0;
      else if (tick) r.duty = c.duty - 1;
    end else begin
      r.duty = 0;
      if (c.age >= HOLD - 1 && c.e2 == 0) r.st = 0;
    end
    r.age = (r.st != c.st) ? 0 : c.age + 1;
    return r;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m <= rst_m();
    else m <= nxt(m, int'(enable), int'(i_fault), int'(i_sw_duty), int'(i_sw_dt1), int'(i_sw_dt2));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk)
    if (rst) begin
      chk("model state", int'(o_state), m.st);
      chk("model duty", int'(o_duty), m.duty);
      chk("model dt1", int'(o_dt1), m.dt1);
      chk("model dt2", int'(o_dt2), m.dt2);
      chk("model pwm_en", int'(o_pwm_en), int'(m.st >= 1 && m.st <= 3));
      chk("model fault", int'(o_fault), int'(m.st == 4));
    end

  task automatic wait_for(input bit on_duty, input int val, input string nm, output int n);
    n = 0;
    while ((on_duty ? int'(o_duty) : int'(o_state)) != val && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, " reached"}, int'(n < 3000), 1);
  endtask

  initial begin
    int n, prev, last_t;
    int vals[$];
    int ts[$];
    rst = 1'b0; enable = 1'b0; i_fault = 1'b0; i_sw_duty = 8'd255; i_sw_dt1 = 4'd0; i_sw_dt2 = 4'd9;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst state", int'(o_state), 0);
    chk("rst duty", int'(o_duty), 0);
    chk("rst pwm_en", int'(o_pwm_en), 0);
    chk("rst fault", int'(o_fault), 0);
    chk("rst dt1", int'(o_dt1), 2);
    chk("rst dt2", int'(o_dt2), 2);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("en edge2 pwm_en", int'(o_pwm_en), 0);
    @(posedge clk);
    #1;
    chk("en edge3 pwm_en", int'(o_pwm_en), 1);
    chk("en edge3 state", int'(o_state), 1);
    chk("load dt1", int'(o_dt1), 2);
    chk("load dt2", int'(o_dt2), 9);
    wait_for(1'b0, 2, "ramp to RUN", n);
    chk("ramp cycles", n, 800);
    chk("ramp clamp duty", int'(o_duty), 200);
    @(negedge clk) i_sw_duty = 8'd50;
    wait_for(1'b1, 50, "track to 50", n);
    repeat (2) @(negedge clk);
    i_sw_duty = 8'd47;
    prev = int'(o_duty);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (int'(o_duty) != prev) begin
        vals.push_back(int'(o_duty));
        ts.push_back(i);
        prev = int'(o_duty);
      end
    end
    chk("track step count", vals.size(), 3);
    if (vals.size() == 3) begin
      chk("track step1", vals[0], 49);
      chk("track step2", vals[1], 48);
      chk("track step3", vals[2], 47);
      chk("track gap1", ts[1] - ts[0], 4);
      chk("track gap2", ts[2] - ts[1], 4);
    end
    chk("track hold", int'(o_duty), 47);
    @(negedge clk) i_sw_duty = 8'd10;
    wait_for(1'b1, 10, "track to 10", n);
    @(negedge clk) enable = 1'b0;
    wait_for(1'b0, 3, "soft stop", n);
    wait_for(1'b1, 5, "ramp down to 5", n);
    chk("down state", int'(o_state), 3);
    @(negedge clk) enable = 1'b1;
    wait_for(1'b0, 1, "re-enable", n);
    chk("resume duty", int'(o_duty), 5);
    wait_for(1'b1, 6, "climb to 6", n);
    @(negedge clk) enable = 1'b0;
    wait_for(1'b0, 0, "stop to IDLE", n);
    chk("idle duty", int'(o_duty), 0);
    chk("idle pwm_en", int'(o_pwm_en), 0);
    @(negedge clk);
    i_sw_duty = 8'd255;
    enable = 1'b1;
    wait_for(1'b1, 30, "ramp to 30", n);
    @(negedge clk) i_fault = 1'b1;
    @(posedge clk);
    #1 i_fault = 1'b0;
    @(posedge clk);
    #1 chk("flt edge2 pwm_en", int'(o_pwm_en), 1);
    @(posedge clk);
    #1;
    chk("flt edge3 pwm_en", int'(o_pwm_en), 0);
    chk("flt edge3 duty", int'(o_duty), 0);
    chk("flt edge3 fault", int'(o_fault), 1);
    repeat (20) @(posedge clk);
    #1 chk("flt held by enable", int'(o_state), 4);
    @(negedge clk) enable = 1'b0;
    wait_for(1'b0, 0, "fault release", n);
    @(negedge clk) i_fault = 1'b1;
    @(posedge clk);
    #1 i_fault = 1'b0;
    wait_for(1'b0, 4, "second fault", n);
    n = 0;
    while (o_state == 3'd4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("fault hold cycles", n, HOLD);
    @(negedge clk);
    enable = 1'b1;
    i_sw_duty = 8'd20;
    i_sw_dt1 = 4'd7;
    i_sw_dt2 = 4'd1;
    wait_for(1'b0, 2, "run at 20", n);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async state", int'(o_state), 0);
    chk("async duty", int'(o_duty), 0);
    chk("async pwm_en", int'(o_pwm_en), 0);
    chk("async fault", int'(o_fault), 0);
    chk("async dt1", int'(o_dt1), 2);
    chk("async dt2", int'(o_dt2), 2);
    @(negedge clk) rst = 1'b1;
    last_t = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      i_fault = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 149) == 0) i_sw_duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0) begin
        i_sw_dt1 = 4'($urandom_range(0, 15));
        i_sw_dt2 = 4'($urandom_range(0, 15));
      end
      if (i - last_t > 200 && $urandom_range(0, 999) == 0) begin
        last_t = i;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
